// File: rtl/sdm_ratio_gen_if.sv
// Control bus of sdm_ratio_gen: update strobe, ratio inputs and registered P/S outputs.
interface sdm_ratio_gen_if #(
    parameter int unsigned P_WIDTH = 5,
    parameter int unsigned S_WIDTH = 3,
    parameter int unsigned F_WIDTH = 8
);
    logic                       LDi;
    logic [P_WIDTH+S_WIDTH-1:0] Ni;
    logic [F_WIDTH-1:0]         Fi;
    logic [P_WIDTH-1:0]         Pi;
    logic [S_WIDTH-1:0]         Si;
    logic                       Vo;
    logic                       ERRo;

    modport master (output LDi, Ni, Fi, input Pi, Si, Vo, ERRo);
    modport slave  (input LDi, Ni, Fi, output Pi, Si, Vo, ERRo);
endinterface

// File: rtl/sdm_ratio_gen.sv
// MASH 1-1-1 ratio generator producing P/S counts for a dual-modulus divider.
// Optional macro SDM_RATIO_GEN_DITHER_EN adds a 15-bit LFSR carry-in dither on stage 1.
module sdm_ratio_gen #(
    parameter int unsigned P_WIDTH = 5,
    parameter int unsigned S_WIDTH = 3,
    parameter int unsigned F_WIDTH = 8
) (
    input  logic                 Fin,
    input  logic                 rst,
    sdm_ratio_gen_if.slave       bus
);
    localparam int unsigned NW = P_WIDTH + S_WIDTH;

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e               state_q;
    logic [F_WIDTH-1:0]   acc1_q, acc2_q, acc3_q;
    logic                 c2_d1_q, c3_d1_q, c3_d2_q;
    logic [P_WIDTH-1:0]   pi_q;
    logic [S_WIDTH-1:0]   si_q;
    logic                 vo_q, err_q;

    logic [F_WIDTH:0]     s1, s2, s3;
    logic [F_WIDTH-1:0]   acc1_d, acc2_d, acc3_d;
    logic                 c1, c2, c3;
    logic                 cin;
    logic signed [3:0]    corr;
    logic signed [NW+1:0] ntot_d;
    logic [NW-1:0]        nclamp_d;
    logic                 clamped_d;
    logic [P_WIDTH-1:0]   pi_d, init_pi;
    logic [S_WIDTH-1:0]   si_d, init_si;
    logic                 err_d, init_err;

`ifdef SDM_RATIO_GEN_DITHER_EN
    logic [14:0] lfsr_q, lfsr_d;
    assign cin    = lfsr_q[0];
    assign lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
`else
    assign cin = 1'b0;
`endif

    always_comb begin
        s1     = {1'b0, acc1_q} + {1'b0, bus.Fi} + {{F_WIDTH{1'b0}}, cin};
        c1     = s1[F_WIDTH];
        acc1_d = s1[F_WIDTH-1:0];
        s2     = {1'b0, acc2_q} + {1'b0, acc1_d};
        c2     = s2[F_WIDTH];
        acc2_d = s2[F_WIDTH-1:0];
        s3     = {1'b0, acc3_q} + {1'b0, acc2_d};
        c3     = s3[F_WIDTH];
        acc3_d = s3[F_WIDTH-1:0];

        corr = $signed({3'b000, c1}) + $signed({3'b000, c2}) - $signed({3'b000, c2_d1_q})
             + $signed({3'b000, c3}) - $signed({2'b00, c3_d1_q, 1'b0}) + $signed({3'b000, c3_d2_q});
        ntot_d = $signed({2'b00, bus.Ni}) + $signed({{(NW-2){corr[3]}}, corr});

        // Sign bit flags underflow; bit NW flags overflow past the largest ratio.
        clamped_d = 1'b1;
        if (ntot_d[NW+1]) begin
            nclamp_d = '0;
        end else if (ntot_d[NW]) begin
            nclamp_d = '1;
        end else begin
            nclamp_d  = ntot_d[NW-1:0];
            clamped_d = 1'b0;
        end
        pi_d  = nclamp_d[NW-1:S_WIDTH];
        si_d  = nclamp_d[S_WIDTH-1:0];
        err_d = clamped_d | ({{P_WIDTH{1'b0}}, si_d} > {{S_WIDTH{1'b0}}, pi_d});

        init_pi  = bus.Ni[NW-1:S_WIDTH];
        init_si  = bus.Ni[S_WIDTH-1:0];
        init_err = {{P_WIDTH{1'b0}}, init_si} > {{S_WIDTH{1'b0}}, init_pi};
    end

    always_ff @(posedge Fin) begin
        if (rst) begin
            state_q <= ST_INIT;
            acc1_q  <= '0;
            acc2_q  <= '0;
            acc3_q  <= '0;
            c2_d1_q <= 1'b0;
            c3_d1_q <= 1'b0;
            c3_d2_q <= 1'b0;
            pi_q    <= '0;
            si_q    <= '0;
            vo_q    <= 1'b0;
            err_q   <= 1'b0;
`ifdef SDM_RATIO_GEN_DITHER_EN
            lfsr_q  <= 15'h0001;
`endif
        end else begin
            case (state_q)
                ST_INIT: begin
                    // First edge out of reset loads the plain Ni split; modulator state is untouched.
                    pi_q    <= init_pi;
                    si_q    <= init_si;
                    err_q   <= init_err;
                    vo_q    <= 1'b1;
                    state_q <= ST_RUN;
                end
                default: begin
                    vo_q <= bus.LDi;
                    if (bus.LDi) begin
                        acc1_q  <= acc1_d;
                        acc2_q  <= acc2_d;
                        acc3_q  <= acc3_d;
                        c2_d1_q <= c2;
                        c3_d2_q <= c3_d1_q;
                        c3_d1_q <= c3;
                        pi_q    <= pi_d;
                        si_q    <= si_d;
                        err_q   <= err_d;
`ifdef SDM_RATIO_GEN_DITHER_EN
                        lfsr_q  <= lfsr_d;
`endif
                    end
                end
            endcase
        end
    end

    assign bus.Pi   = pi_q;
    assign bus.Si   = si_q;
    assign bus.Vo   = vo_q;
    assign bus.ERRo = err_q;
endmodule
